// File: rtl/hs32_defs.sv
// Shared hs32 definitions: word width, PC step, fetch state encoding and FIFO entry layout.
package hs32_defs;
  localparam int          HS32_WORD    = 32;
  localparam logic [31:0] HS32_PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_REQ     = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [HS32_WORD-1:0] pc;
    logic [HS32_WORD-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/hs32_fifo.sv
// Synchronous FIFO with clear; head data is registered storage, shared with the load/store unit.
module hs32_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd, wr;
  logic [AW:0]      cnt;
  logic             do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop)  rd <= rd + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !(reset || clear)) mem[wr] <= wdata;
  end
endmodule

// File: rtl/hs32_fetch.sv
// hs32 instruction fetch: sequential word fetch over reqm/ackm into a FIFO, with flush redirect.
// Define HS32_FETCH_BYPASS_EN to forward an ack straight to decode when the FIFO is empty.
module hs32_fetch
  import hs32_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] addr,
  input  logic [31:0] dtr,
  output logic        reqm,
  input  logic        ackm,
  input  logic [31:0] newpc,
  input  logic        flush,
  output logic [31:0] instd,
  output logic        iready,
  input  logic        dready,
  output logic [31:0] pcd
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t state, state_nxt;
  logic [31:0]  pc, pc_nxt, addr_q, addr_nxt, tgt;
  fetch_entry_t head, wentry;
  logic         push, pop, full, empty, bypass, room_now, room_after;
  logic [CW-1:0] count;
  logic [CW:0]   occ_after;

  assign tgt    = newpc & ~32'h3;
  assign pop    = ~empty & dready & ~flush;
  assign wentry = {pc, dtr};

`ifdef HS32_FETCH_BYPASS_EN
  assign bypass = (state == FS_REQ) & ackm & empty & dready & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign push       = (state == FS_REQ) & ackm & ~flush & ~bypass;
  assign room_now   = ~full | pop;
  assign occ_after  = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
  assign room_after = occ_after < (CW+1)'(DEPTH);

  hs32_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FS_IDLE;
      pc     <= RESET_PC & ~32'h3;
      addr_q <= RESET_PC & ~32'h3;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = addr_q;
    case (state)
      FS_IDLE: if (room_now) begin
        state_nxt = FS_REQ;
        addr_nxt  = pc;
      end
      FS_REQ: if (ackm) begin
        pc_nxt    = pc + HS32_PC_STEP;
        addr_nxt  = pc + HS32_PC_STEP;
        state_nxt = room_after ? FS_REQ : FS_IDLE;
      end
      FS_DISCARD: if (ackm) begin
        state_nxt = FS_REQ;
        addr_nxt  = pc;
      end
      default: state_nxt = FS_IDLE;
    endcase
    // an open arbiter transaction cannot be withdrawn, so pc carries the target until it completes
    if (flush) begin
      pc_nxt = tgt;
      if (state == FS_IDLE || ackm) begin
        state_nxt = FS_REQ;
        addr_nxt  = tgt;
      end else begin
        state_nxt = FS_DISCARD;
        addr_nxt  = addr_q;
      end
    end
  end

  assign reqm   = (state != FS_IDLE);
  assign addr   = addr_q;
  assign iready = ~empty | bypass;
  assign instd  = bypass ? dtr : (empty ? '0 : head.inst);
  assign pcd    = bypass ? pc  : (empty ? '0 : head.pc);
endmodule

// File: tb/tb_hs32_fetch.sv
// Scoreboard bench for hs32_fetch: randomized arbiter/decode/flush traffic against an address-stream model.
module tb_hs32_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] addr, dtr = '0, newpc = '0, instd, pcd;
  logic        reqm, ackm = 1'b0, flush = 1'b0, iready, dready = 1'b1;

  always #5 clk = ~clk;

  hs32_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addr(addr), .dtr(dtr), .reqm(reqm), .ackm(ackm),
    .newpc(newpc), .flush(flush), .instd(instd), .iready(iready), .dready(dready), .pcd(pcd)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t        q[$];
  int          checks = 0, errors = 0;
  logic [31:0] exp_pc = RST_PC, held_addr = '0;
  bit          stale = 0, exp_ird = 0, chk_en = 0, prev_wait = 0, dready_rand = 0;
  int          ack_mode = 0, acks_seen = 0, pops_seen = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // one clock: arbiter and redirect inputs change 1ns after the edge
  task automatic step(input bit fl = 0, input logic [31:0] np = 0);
    @(posedge clk); #1;
    flush = fl;
    newpc = fl ? np : $urandom;
    case (ack_mode)
      0:       ackm = reqm;
      1:       ackm = reqm && prev_wait;
      2:       ackm = reqm && ($urandom_range(0, 1) == 1);
      default: ackm = 1'b0;
    endcase
    prev_wait = reqm && !ackm;
    dtr = ackm ? mem(addr) : $urandom;
    if (dready_rand) dready = ($urandom_range(0, 3) != 0);
  endtask

  // reference: expected fetch stream = consecutive words from the last redirect target
  always @(negedge clk) begin
    int  qb, popn;
    bit  byp;
    if (reset) begin
      q.delete(); exp_pc = RST_PC; stale = 0; exp_ird = 0; chk_en = 0;
    end else begin
      chk_en = 1;
      qb   = q.size();
      byp  = 0;
      popn = (qb > 0 && dready) ? 1 : 0;
      if (stale) begin
        chk("discard_reqm", reqm, 1'b1);
        chk("discard_addr", addr, held_addr);
      end else if (reqm) begin
        chk("fetch_addr", addr, exp_pc);
      end
      if (reqm && ackm) begin
        acks_seen++;
        if (stale) stale = 0;
        else if (!flush) begin
          chk("fifo_room", (qb - popn) < DEPTH, 1'b1);
`ifdef HS32_FETCH_BYPASS_EN
          if (qb == 0 && dready) byp = 1;
`endif
          q.push_back('{pc: exp_pc, inst: mem(exp_pc)});
          exp_pc += 32'd4;
        end
      end
      exp_ird = (qb != 0) || byp;
      if (flush) begin
        q.delete();
        exp_pc = newpc & ~32'h3;
        if (reqm && !ackm) begin
          if (!stale) held_addr = addr;
          stale = 1;
        end
      end
    end
  end

  // monitor: consumes the scoreboard whenever decode takes a word
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (chk_en) begin
      chk("iready", iready, exp_ird);
      if (iready && dready && !flush) begin
        pops_seen++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pop_empty: got pcd %h expected no word", pcd);
        end else begin
          e = q.pop_front();
          chk("pcd", pcd, e.pc);
          chk("instd", instd, e.inst);
        end
      end
    end
  end

  initial begin
    repeat (3) step();
    chk("rst_reqm", reqm, 1'b0);
    chk("rst_addr", addr, RST_PC);
    chk("rst_iready", iready, 1'b0);
    chk("rst_instd", instd, 32'h0);
    chk("rst_pcd", pcd, 32'h0);

    // ack one cycle after each request
    ack_mode = 1; reset = 0;
    step();
    chk("first_reqm", reqm, 1'b1);
    chk("first_addr", addr, RST_PC);
    repeat (30) step();

    // decode stalled: FIFO fills, fetch stops
    reset = 1; step(); step();
    acks_seen = 0; dready = 0; ack_mode = 0; reset = 0;
    repeat (10) step();
    chk("stall_acks", acks_seen, 2);
    chk("stall_reqm", reqm, 1'b0);
    chk("stall_pcd", pcd, 32'h0);
    chk("stall_instd", instd, mem(32'h0));

    // resume at 0x8, then redirect while that request is still open
    dready = 1; ack_mode = 3;
    step();
    chk("resume_addr", addr, 32'h8);
    step(1, 32'h100);
    step(); step();
    chk("hold_addr", addr, 32'h8);
    ack_mode = 0;
    step(); step();
    chk("redir_reqm", reqm, 1'b1);
    chk("redir_addr", addr, 32'h100);

    // redirect coincident with an ack, unaligned target
    repeat (5) step();
    step(1, 32'h203);
    step();
    chk("flush_ack_addr", addr, 32'h200);
`ifdef HS32_FETCH_BYPASS_EN
    chk("bypass_iready", iready, 1'b1);
    chk("bypass_pcd", pcd, 32'h200);
`else
    chk("flush_ack_iready", iready, 1'b0);
    step();
    chk("flush_ack_iready1", iready, 1'b1);
    chk("flush_ack_pcd", pcd, 32'h200);
`endif

    // one instruction per cycle at full rate
    repeat (4) step();
    pops_seen = 0;
    repeat (20) step();
    chk("throughput", pops_seen, 20);

    // address wrap
    step(1, 32'hFFFF_FFF8);
    step(); step(); step();
    chk("wrap_addr", addr, 32'h0);

    // reset lands on an ack cycle
    repeat (3) step();
    reset = 1;
    step();
    reset = 0;
    chk("midrst_reqm", reqm, 1'b0);
    chk("midrst_iready", iready, 1'b0);
    chk("midrst_addr", addr, RST_PC);
    step();
    chk("midrst_refetch", addr, RST_PC);

    // random traffic
    dready_rand = 1; ack_mode = 2;
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) step(1, $urandom);
      else if (r == 4) begin
        reset = 1; step(); reset = 0;
      end else step();
      if (i % 500 == 250) ack_mode = 0;
      if (i % 500 == 0)   ack_mode = 2;
    end
    dready_rand = 0; dready = 1;
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hs32_fetch.md
Name: hs32_fetch

Overview:
- Instruction fetch stage of the hs32 core, directly upstream of decode/execute.
- Generates sequential word addresses, requests instructions from the memory arbiter over the reqm/ackm handshake, and buffers them in a small FIFO for decode.
- Consumes the newpc/flush redirect driven by the execute stage.
- On flush: discards all buffered and in-flight instructions and restarts fetching at newpc.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction FIFO entries; power of two, 2..8.

Ports:
- clk  input  1  core clock (12 MHz)
- reset  input  1  synchronous, active-high reset
- addr  output  32  memory address to arbiter
- dtr  input  32  memory read data
- reqm  output  1  request valid; addr stable while high
- ackm  input  1  data valid; one-cycle pulse completing a request
- newpc  input  32  redirect target from execute
- flush  input  1  redirect strobe from execute, one cycle
- instd  output  32  instruction word to decode
- iready  output  1  instd valid
- dready  input  1  decode accepts instd this cycle
- pcd  output  32  address of the word on instd

Behaviour:
- Reset (clk edge with reset=1):
  - pc=RESET_PC, addr=RESET_PC, reqm=0, FIFO empty, iready=0, instd=0, pcd=0, state=IDLE.
  - Reset wins over every other input, including mid-transaction; a pending ackm after reset is ignored.
- States:
  - IDLE: reqm=0. If FIFO has a free slot (counting the entry about to drain this cycle), go to REQ next cycle with addr=pc.
  - REQ: reqm=1, addr=pc, both held until ackm=1. On ackm:
    - write {pc, dtr} into FIFO; pc=pc+4 (wraps mod 2^32).
    - If FIFO still has room after the write, stay in REQ with addr=pc+4 and reqm held high (back-to-back); else go to IDLE.
  - DISCARD: entered when flush arrives while reqm=1 and ackm=0. The arbiter transaction cannot be aborted:
    - keep reqm=1 with the old addr until ackm, then drop the data.
    - Then go to REQ at the latched redirect pc.
- Flush:
  - Same cycle: FIFO cleared, iready=0 next cycle, pc=newpc.
  - If ackm=1 in the flush cycle, that data is dropped and the next cycle is REQ at newpc.
  - A second flush during DISCARD overwrites the latched target (last wins).
- Alignment: newpc[1:0] ignored; addr[1:0] always 2'b00.
- Decode handshake:
  - instd/pcd are the FIFO head; iready = FIFO non-empty.
  - Pop occurs when iready & dready & ~flush.
  - instd/pcd stable while iready=1 and dready=0.
- Simultaneous push and pop with FIFO full is legal; occupancy is unchanged.
- Latency:
  - ackm edge to iready=1 is 1 cycle (registered FIFO).
  - flush to reqm at newpc is 1 cycle, unless in DISCARD.
- Throughput: with ackm same-cycle as reqm and dready=1, one instruction per cycle.

Optional Feature:
- Macro: HS32_FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, dready=1, ackm=1 and no flush, dtr/pc go combinationally to instd/pcd with iready=1 in the ackm cycle, and the word is not pushed. Saves 1 cycle of latency.
- Undefined: all words pass through the FIFO; the 1-cycle latency above holds.

Decomposition:
- Shared package/include (hs32_defs):
  - fetch state encodings FS_IDLE, FS_REQ, FS_DISCARD.
  - HS32_WORD width 32.
  - HS32_PC_STEP 4.
- Sub-module hs32_fifo:
  - synchronous FIFO, parameters WIDTH/DEPTH.
  - push/pop/clear, full/empty, head data.
  - reused later by the load/store unit.
  - Here WIDTH=64 (pc + instruction).

Test Plan:
- Reset release, ackm one cycle after each reqm, dready=1 -> first addr=0x0, then 0x4, 0x8; pcd/instd pairs match the memory model; iready rises 1 cycle after each ackm.
- dready=0 for 10 cycles with DEPTH=2 -> exactly 2 acks accepted, reqm drops, instd holds the 0x0 word; dready=1 -> fetch resumes at 0x8.
- Flush newpc=0x100 while reqm=1 to 0x8 and ackm delayed 3 cycles -> addr holds 0x8 until ack, that data never appears on instd, next reqm addr=0x100.
- Flush newpc=0x203 coincident with ackm -> ack data dropped, next addr=0x200, first iready word has pcd=0x200.
- pc=0xFFFF_FFFC fetched -> next addr wraps to 0x0000_0000.
- Reset asserted mid-REQ with ackm arriving the same cycle -> reqm=0, FIFO empty, next fetch at RESET_PC; with HS32_FETCH_BYPASS_EN, an ack on an empty FIFO with dready=1 shows iready=1 in the ack cycle.
